// File: rtl/led_seq_monitor.sv
// led_seq_monitor: receive-side checker for the one-hot blue -> green -> red
// light bus. Registers the bus, decodes the colour, and checks encoding,
// colour order and per-colour dwell. Reports lock state, per-error strobes
// and saturating rotation/error counters.
module led_seq_monitor #(
    parameter int DWELL      = 1,
    parameter int LOCK_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light,
    output logic [1:0]       colour,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] rot_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int RUN_W  = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam int GOOD_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        C_NONE  = 2'b00,
        C_RED   = 2'b01,
        C_BLUE  = 2'b10,
        C_GREEN = 2'b11
    } colour_t;

    typedef enum logic [1:0] {
        E_NONE  = 2'b00,
        E_ENC   = 2'b01,
        E_ORDER = 2'b10,
        E_DWELL = 2'b11
    } err_t;

    function automatic colour_t decode(input logic [2:0] l);
        case (l)
            3'b001:  decode = C_RED;
            3'b010:  decode = C_BLUE;
            3'b100:  decode = C_GREEN;
            default: decode = C_NONE;
        endcase
    endfunction

    function automatic colour_t successor(input colour_t c);
        case (c)
            C_BLUE:  successor = C_GREEN;
            C_GREEN: successor = C_RED;
            C_RED:   successor = C_BLUE;
            default: successor = C_NONE;
        endcase
    endfunction

    logic [2:0]       light_q, light_d;
    state_t           state_q, state_d;
    colour_t          prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [GOOD_W-1:0] good_q, good_d;
    colour_t          colour_q, colour_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    err_t             err_code_q, err_code_d;
    logic [CNT_W-1:0] rot_count_q, rot_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    colour_t cur;
    err_t    err;
    logic    rot_inc;

    // Next-state: classify the registered sample and update tracking state.
    always_comb begin
        light_d  = light;
        cur      = decode(light_q);
        colour_d = cur;
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        good_d   = good_q;
        err      = E_NONE;
        rot_inc  = 1'b0;

        case (state_q)
            HUNT: begin
                if (cur != C_NONE) begin
                    state_d = TRACK;
                    prev_d  = cur;
                    run_d   = RUN_W'(1);
                    good_d  = '0;
                end
            end
            default: begin
                if (cur == C_NONE) begin
                    err     = E_ENC;
                    state_d = HUNT;
                    prev_d  = C_NONE;
                    run_d   = '0;
                    good_d  = '0;
                end else if (cur == prev_q) begin
                    if (run_q == RUN_W'(DWELL)) begin
                        err = E_DWELL;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else if (cur != successor(prev_q)) begin
                    err = E_ORDER;
                end else if (run_q != RUN_W'(DWELL)) begin
                    err = E_DWELL;
                end else begin
                    run_d  = RUN_W'(1);
                    prev_d = cur;
                    if (state_q == TRACK) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        rot_inc = (prev_q == C_RED) && (cur == C_BLUE);
                    end
                end
                // Order and dwell errors restart tracking on the current,
                // necessarily legal, sample.
                if (err == E_ORDER || err == E_DWELL) begin
                    state_d = TRACK;
                    prev_d  = cur;
                    run_d   = RUN_W'(1);
                    good_d  = '0;
                end
            end
        endcase

        locked_d    = (state_d == LOCKED);
        err_pulse_d = (err != E_NONE);
        err_code_d  = err;
        err_count_d = err_count_q;
        if (err != E_NONE && err_count_q != '1) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        rot_count_d = rot_count_q;
        if (rot_inc && rot_count_q != '1) begin
            rot_count_d = rot_count_q + CNT_W'(1);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            light_q     <= '0;
            state_q     <= HUNT;
            prev_q      <= C_NONE;
            run_q       <= '0;
            good_q      <= '0;
            colour_q    <= C_NONE;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= E_NONE;
            rot_count_q <= '0;
            err_count_q <= '0;
        end else begin
            light_q     <= light_d;
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            good_q      <= good_d;
            colour_q    <= colour_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            rot_count_q <= rot_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign colour    = colour_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign rot_count = rot_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_led_seq_monitor.sv
// Directed bench for led_seq_monitor: three instances cover the default
// configuration, DWELL=2 and CNT_W=2. Outputs are sampled on the falling
// edge; after each put() the outputs reflect the sample driven one put earlier.
module tb_led_seq_monitor;

    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LB = 3'b010;
    localparam logic [2:0] LG = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] l0, l1, l2;
    logic [1:0] c0, c1, c2, ec0, ec1, ec2;
    logic       lk0, lk1, lk2, ep0, ep1, ep2;
    logic [7:0] rc0, erc0, rc1, erc1;
    logic [1:0] rc2, erc2;

    int n_checks = 0;
    int n_pass   = 0;

    led_seq_monitor #(.DWELL(1), .LOCK_COUNT(3), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .light(l0), .colour(c0), .locked(lk0),
        .err_pulse(ep0), .err_code(ec0), .rot_count(rc0), .err_count(erc0));

    led_seq_monitor #(.DWELL(2), .LOCK_COUNT(3), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .light(l1), .colour(c1), .locked(lk1),
        .err_pulse(ep1), .err_code(ec1), .rot_count(rc1), .err_count(erc1));

    led_seq_monitor #(.DWELL(1), .LOCK_COUNT(3), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .light(l2), .colour(c2), .locked(lk2),
        .err_pulse(ep2), .err_code(ec2), .rot_count(rc2), .err_count(erc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic put(input int which, input logic [2:0] v);
        case (which)
            0:       l0 = v;
            1:       l1 = v;
            default: l2 = v;
        endcase
        @(negedge clk);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, ".colour"}, 32'(c0), 0);
        chk({tag, ".locked"}, 32'(lk0), 0);
        chk({tag, ".err_pulse"}, 32'(ep0), 0);
        chk({tag, ".err_code"}, 32'(ec0), 0);
        chk({tag, ".rot_count"}, 32'(rc0), 0);
        chk({tag, ".err_count"}, 32'(erc0), 0);
    endtask

    logic [2:0] t1 [0:10];
    int         e1c [0:9];
    int         e1l [0:9];
    int         e1r [0:9];
    logic [2:0] t4 [0:24];
    int         e4 [0:24];
    logic [2:0] t5 [0:11];
    int         e5 [0:11];
    int         model_cnt;
    int         pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        t1  = '{LB, LG, LR, LB, LG, LR, LB, LG, LR, LB, 3'b011};
        e1c = '{2, 3, 1, 2, 3, 1, 2, 3, 1, 2};
        e1l = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        e1r = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2};
        t4  = '{LB, LB, LG, LG, LR, LR, LB, LB, LG, LG, LR, LR, LB,
                LB, LB, LB, LG, LG, LR, LR, LB, LG, LG, LR, LR};
        e4  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 3, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0};
        t5  = '{LB, 3'b111, LB, 3'b111, LB, 3'b111, LB, 3'b111, LB, 3'b111, LB, LB};
        e5  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0};

        rst_n = 1'b0;
        l0 = '0; l1 = '0; l2 = '0;
        repeat (3) @(negedge clk);
        chk_zero0("reset");
        chk("reset.u1.err_count", 32'(erc1), 0);
        chk("reset.u2.err_count", 32'(erc2), 0);
        rst_n = 1'b1;

        // Clean rotations, lock after the third good transition.
        for (int i = 0; i <= 10; i++) begin
            put(0, t1[i]);
            if (i > 0) begin
                chk($sformatf("rot.colour[%0d]", i - 1), 32'(c0), 32'(e1c[i-1]));
                chk($sformatf("rot.locked[%0d]", i - 1), 32'(lk0), 32'(e1l[i-1]));
                chk($sformatf("rot.rot_count[%0d]", i - 1), 32'(rc0), 32'(e1r[i-1]));
                chk($sformatf("rot.err_pulse[%0d]", i - 1), 32'(ep0), 0);
            end
        end
        chk("rot.err_count", 32'(erc0), 0);

        // Illegal encoding while locked.
        put(0, LB);
        chk("enc.err_pulse", 32'(ep0), 1);
        chk("enc.err_code", 32'(ec0), 1);
        chk("enc.locked", 32'(lk0), 0);
        chk("enc.err_count", 32'(erc0), 1);
        chk("enc.rot_count", 32'(rc0), 2);
        chk("enc.colour", 32'(c0), 0);
        put(0, LG);
        chk("hunt.err_pulse", 32'(ep0), 0);
        chk("hunt.err_code", 32'(ec0), 0);
        chk("hunt.colour", 32'(c0), 2);
        put(0, LR);
        put(0, LB);
        chk("relock.pre", 32'(lk0), 0);
        put(0, LR);
        chk("relock.locked", 32'(lk0), 1);
        chk("relock.rot_count", 32'(rc0), 2);

        // Bad order B -> R, reseed on red.
        put(0, LB);
        chk("order.err_pulse", 32'(ep0), 1);
        chk("order.err_code", 32'(ec0), 2);
        chk("order.err_count", 32'(erc0), 2);
        chk("order.locked", 32'(lk0), 0);
        put(0, LG);
        chk("reseed.rb.err_pulse", 32'(ep0), 0);
        put(0, LR);
        chk("reseed.bg.err_pulse", 32'(ep0), 0);
        put(0, LB);
        chk("reseed.gr.locked", 32'(lk0), 1);
        chk("reseed.gr.err_count", 32'(erc0), 2);
        chk("reseed.gr.rot_count", 32'(rc0), 2);

        // Build rot_count up to 5 while locked.
        put(0, LG);
        chk("rot3", 32'(rc0), 3);
        put(0, LR);
        put(0, LB);
        put(0, LG);
        chk("rot4", 32'(rc0), 4);
        put(0, LR);
        put(0, LB);
        put(0, LG);
        chk("rot5", 32'(rc0), 5);
        chk("rot5.locked", 32'(lk0), 1);

        // Reset glitch between edges must be ignored.
        l0 = LR;
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("glitch.rot_count", 32'(rc0), 5);
        chk("glitch.locked", 32'(lk0), 1);
        chk("glitch.err_count", 32'(erc0), 2);
        chk("glitch.colour", 32'(c0), 3);

        // One-edge reset mid-operation.
        rst_n = 1'b0;
        l0 = '0;
        @(negedge clk);
        chk_zero0("midreset");
        rst_n = 1'b1;
        put(0, '0);
        put(0, LG);
        chk("hunt0.err_pulse", 32'(ep0), 0);
        put(0, LR);
        chk("hunt0.colour", 32'(c0), 3);
        chk("hunt0.locked", 32'(lk0), 0);
        chk("hunt0.err_pulse2", 32'(ep0), 0);
        put(0, LB);
        chk("hunt0.track", 32'(ep0), 0);

        // DWELL=2: clean runs, then over-long and too-short runs.
        model_cnt = 0;
        for (int i = 0; i <= 24; i++) begin
            put(1, t4[i]);
            if (i > 0) begin
                if (e4[i-1] != 0) model_cnt++;
                chk($sformatf("dwell.err_code[%0d]", i - 1), 32'(ec1), 32'(e4[i-1]));
                chk($sformatf("dwell.err_pulse[%0d]", i - 1), 32'(ep1), 32'(e4[i-1] != 0));
                chk($sformatf("dwell.err_count[%0d]", i - 1), 32'(erc1), 32'(model_cnt));
            end
            if (i == 14) begin
                chk("dwell.locked", 32'(lk1), 1);
                chk("dwell.rot_count", 32'(rc1), 1);
            end
        end

        // CNT_W=2: error counter saturates at 3.
        model_cnt = 0;
        pulses = 0;
        for (int i = 0; i <= 11; i++) begin
            put(2, t5[i]);
            if (i > 0) begin
                if (e5[i-1] != 0) model_cnt = (model_cnt == 3) ? 3 : model_cnt + 1;
                if (ep2 === 1'b1) pulses++;
                chk($sformatf("sat.err_code[%0d]", i - 1), 32'(ec2), 32'(e5[i-1]));
                chk($sformatf("sat.err_count[%0d]", i - 1), 32'(erc2), 32'(model_cnt));
            end
        end
        chk("sat.pulses", 32'(pulses), 5);
        chk("sat.final", 32'(erc2), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_seq_monitor.md
Name: led_seq_monitor

Overview:
Receive-side checker for the 3-bit one-hot traffic/status light bus driven by the team's LED sequencer FSMs. Samples the light bus every clock, decodes the active colour, and verifies encoding, colour order (blue -> green -> red -> blue) and per-colour dwell time. Reports lock status, error events and saturating rotation and error counters to the status/debug logic.

Parameters:
DWELL, 1, number of consecutive clock samples each colour must be held (>=1)
LOCK_COUNT, 3, consecutive good transitions required before asserting locked (>=1)
CNT_W, 8, width of rot_count and err_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
light  input  3  one-hot light bus: 3'b001 red, 3'b010 blue, 3'b100 green
colour  output  2  decoded sampled colour: 00 none/invalid, 01 red, 10 blue, 11 green
locked  output  1  high while sequence is verified (state LOCKED)
err_pulse  output  1  one-cycle strobe per detected error
err_code  output  2  error type, valid only with err_pulse, else 00: 01 illegal encoding, 10 bad order, 11 dwell violation
rot_count  output  CNT_W  completed rotations (red -> blue transitions while LOCKED), saturating
err_count  output  CNT_W  total errors, saturating

Behaviour:
- Clocking: single clock, fully synchronous. Reset is synchronous and active-low; rst_n is sampled only on the rising edge of clk.
- Reset: every output is 0 (colour 00, locked 0, err_pulse 0, err_code 00, both counters 0). State HUNT, run counter 0, good counter 0.
- Latency: light is registered into light_q on edge n. All outputs reflecting that sample update on edge n+1, so outputs appear two edges after light changes. colour is the registered decode of light_q.
- Legal sample: light_q is exactly one of 001, 010 or 100. Successor map: blue -> green -> red -> blue.
- Run counter: counts consecutive samples of the same colour, width clog2(DWELL+1).
- State HUNT:
  - An invalid sample, including 000, raises no error and stays in HUNT.
  - The first legal sample moves to TRACK with run=1, good=0.
- States TRACK and LOCKED, evaluated per sample in this priority order:
  1. Illegal encoding: error 01. Go to HUNT; run=0, good=0.
  2. Same colour as previous sample: run+1. If run would exceed DWELL, error 11.
  3. Different colour that is not the successor: error 10.
  4. Successor colour but previous run != DWELL: error 11.
  5. Otherwise, a good transition:
     - run=1.
     - In TRACK, good+1; when good reaches LOCK_COUNT, enter LOCKED. The transition that achieves lock does not increment rot_count.
     - In LOCKED, a red -> blue transition increments rot_count.
- After errors 10 and 11: reseed on the current sample. Go to TRACK with run=1, good=0. The sample is legal by construction.
- Any error:
  - err_pulse=1 for exactly one cycle with the matching err_code.
  - err_count+1.
  - locked drops to 0 on the same edge.
  - rot_count is retained.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Only one error can be reported per sample. Consecutive erroring samples produce back-to-back err_pulse cycles.
- Reset mid-operation: reset overrides all activity on that edge and clears counters and state. A glitch on rst_n between edges has no effect.

Test Plan:
1. DWELL=1, LOCK_COUNT=3. Drive B,G,R,B,G,R,B,G,R,B after reset.
   - locked rises on the edge after the 3rd transition is evaluated.
   - After all samples: rot_count=2, err_count=0, err_pulse never high.
   - colour tracks input as 10,11,01 with 2-edge latency.
2. While locked, drive light=3'b011 for one cycle.
   - err_pulse=1 for one cycle, err_code=01, locked=0, err_count=1.
   - Monitor returns to HUNT, then to TRACK on the next legal colour.
3. While locked, drive B then R.
   - err_code=10, err_count+1.
   - Reseed on red: a following R->B->G sequence yields good transitions with no further errors.
4. DWELL=2, drive B,B,G,G,R,R,B,B: no errors.
   - Then B,B,B: err_code=11 on the 3rd B.
   - Then B,G (run of 1 before G): err_code=11.
5. CNT_W=2, inject 5 illegal samples (3'b111) separated by legal colours: err_count saturates at 3 and err_pulse fires 5 times.
6. Drive rst_n low for one edge while locked with rot_count=5.
   - Next edge: every output is 0 and the monitor is in HUNT.
   - A 2 ns low pulse between edges changes nothing.
